// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
// Parallel-to-serial feeder for the Moore sequence detector. A word is accepted
// over a valid/ready handshake and its bits are emitted on x, one per clock.
// x_valid and word_done frame the stream for downstream logging.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous reset, active-high
//   in_data    parallel word, captured only on an accept edge
//   in_valid   source has a word available
//   in_ready   serializer can take a word this cycle (never depends on in_valid)
//   x          registered serial bit, IDLE_BIT when x_valid is low
//   x_valid    registered, x carries a data bit this cycle
//   word_done  high while the last bit of a word is on x
//   bit_idx    emission-order index of the bit currently on x
//   busy       serializer is in the SHIFT state
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
   parameter int unsigned  WIDTH     = 8,
   parameter bit           MSB_FIRST = 1'b1,
   parameter bit           IDLE_BIT  = 1'b0,
   localparam int unsigned CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x,
   output logic             x_valid,
   output logic             word_done,
   output logic [CW-1:0]    bit_idx,
   output logic             busy
);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] w_sreg_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_x;
   logic             r_x_valid;
   logic             w_last;
   logic             w_accept;
   logic             w_first_bit;
   logic             w_next_bit;

   // Next-state and handshake logic
   always_comb begin
      w_state_next = r_state;
      w_last       = (r_state == S_SHIFT) && (r_cnt == LAST_IDX);
      // Ready again on the last bit so a following word streams with no gap.
      in_ready     = !rst && ((r_state == S_IDLE) || w_last);
      w_accept     = in_valid && in_ready;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = S_SHIFT;
         S_SHIFT: if (w_last && !w_accept) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // The shift register always holds the word with the bit currently on x at
   // its emitting end; shifting exposes the next bit for the following cycle.
   always_comb begin
      w_sreg_shift = MSB_FIRST ? (r_sreg << 1) : (r_sreg >> 1);
      w_first_bit  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
      w_next_bit   = MSB_FIRST ? w_sreg_shift[WIDTH-1] : w_sreg_shift[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sreg    <= '0;
         r_cnt     <= '0;
         r_x       <= IDLE_BIT;
         r_x_valid <= 1'b0;
      end else if (w_accept) begin
         r_sreg    <= in_data;
         r_cnt     <= '0;
         r_x       <= w_first_bit;
         r_x_valid <= 1'b1;
      end else if (r_state == S_SHIFT) begin
         if (w_last) begin
            r_cnt     <= '0;
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
         end else begin
            r_sreg    <= w_sreg_shift;
            r_cnt     <= r_cnt + 1'b1;
            r_x       <= w_next_bit;
         end
      end
   end

   always_comb begin
      x         = r_x;
      x_valid   = r_x_valid;
      word_done = w_last;
      bit_idx   = r_cnt;
      busy      = (r_state == S_SHIFT);
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
// Three serializer instances: 8-bit MSB-first (d=0), 8-bit LSB-first (d=1) and
// 1-bit with IDLE_BIT=1 (d=2). Accepted words push their expected bits, with
// the cycle each must appear in, onto a scoreboard; a negedge monitor pops and
// compares whenever an instance presents x_valid.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

   typedef struct {
      int dut;
      bit x;
      int idx;
      bit done;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din [3];
   logic       iv  [3];
   logic       ir  [3];
   logic       xo  [3];
   logic       xv  [3];
   logic       wd  [3];
   logic       by  [3];
   logic [2:0] bi  [3];
   logic [2:0] bi0;
   logic [2:0] bi1;
   logic       bi2;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      bi[0] = bi0;
      bi[1] = bi1;
      bi[2] = {2'b00, bi2};
   end

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
      .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(iv[0]), .in_ready(ir[0]),
      .x(xo[0]), .x_valid(xv[0]), .word_done(wd[0]), .bit_idx(bi0), .busy(by[0]));

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(iv[1]), .in_ready(ir[1]),
      .x(xo[1]), .x_valid(xv[1]), .word_done(wd[1]), .bit_idx(bi1), .busy(by[1]));

   seq_bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_w1 (
      .clk(clk), .rst(rst), .in_data(din[2][0:0]), .in_valid(iv[2]), .in_ready(ir[2]),
      .x(xo[2]), .x_valid(xv[2]), .word_done(wd[2]), .bit_idx(bi2), .busy(by[2]));

   function automatic int wid(input int d);
      return (d == 2) ? 1 : 8;
   endfunction

   function automatic int idle_of(input int d);
      return (d == 2) ? 1 : 0;
   endfunction

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // stream[w-1] is the first bit emitted; bit i is expected in cycle k+i.
   function automatic void push(input int d, input logic [7:0] stream, input int k);
      exp_t e;
      for (int i = 0; i < wid(d); i++) begin
         e.dut  = d;
         e.x    = stream[wid(d)-1-i];
         e.idx  = i;
         e.done = (i == wid(d) - 1);
         e.cyc  = k + i;
         sbq.push_back(e);
      end
   endfunction

   // Monitor: compares every presented bit against the scoreboard.
   always @(negedge clk) begin
      int   fi;
      exp_t e;
      if (mon_en) begin
         for (int d = 0; d < 3; d++) begin
            fi = -1;
            for (int i = 0; i < sbq.size(); i++) begin
               if (sbq[i].dut == d) begin
                  fi = i;
                  break;
               end
            end
            if (xv[d]) begin
               if (fi < 0) begin
                  chk($sformatf("d%0d_unexpected_bit", d), xv[d], 0);
               end else begin
                  e = sbq[fi];
                  sbq.delete(fi);
                  chk($sformatf("d%0d_x_bit%0d", d, e.idx), xo[d], e.x);
                  chk($sformatf("d%0d_bit_idx", d), bi[d], e.idx);
                  chk($sformatf("d%0d_word_done_bit%0d", d, e.idx), wd[d], e.done);
                  chk($sformatf("d%0d_bit_cycle", d), cyc, e.cyc);
               end
            end else begin
               chk($sformatf("d%0d_idle_x", d), xo[d], idle_of(d));
               chk($sformatf("d%0d_idle_word_done", d), wd[d], 0);
               if (fi >= 0 && sbq[fi].cyc <= cyc) begin
                  chk($sformatf("d%0d_missing_bit%0d", d, sbq[fi].idx), xv[d], 1);
                  sbq.delete(fi);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a word and holds it until accepted. With vary set, in_data is
   // changed every waiting cycle and the value held at the accept edge is
   // expected (MSB-first instance only).
   task automatic send(input int d, input logic [7:0] data, input logic [7:0] stream,
                       input bit vary, input int budget, output int waited);
      int         n;
      logic [7:0] cap;
      n      = 0;
      waited = -1;
      din[d] = data;
      iv[d]  = 1'b1;
      while (!ir[d] && n < budget) begin
         tick();
         n++;
         if (vary) din[d] = data ^ n[7:0];
      end
      if (!ir[d]) begin
         chk($sformatf("d%0d_send_timeout", d), ir[d], 1);
         iv[d] = 1'b0;
         return;
      end
      cap = din[d];
      tick();
      push(d, vary ? cap : stream, cyc);
      iv[d]  = 1'b0;
      waited = n;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         iv[d]  = 1'b1;
         din[d] = 8'hFF;
      end

      // Reset with in_valid high: nothing accepted, outputs idle.
      for (int c = 0; c < 2; c++) begin
         tick();
         mon_en = 1'b1;
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_rst_in_ready", d), ir[d], 0);
            chk($sformatf("d%0d_rst_x_valid", d), xv[d], 0);
            chk($sformatf("d%0d_rst_x", d), xo[d], idle_of(d));
            chk($sformatf("d%0d_rst_busy", d), by[d], 0);
         end
      end
      rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d_post_rst_in_ready", d), ir[d], 1);
         chk($sformatf("d%0d_post_rst_busy", d), by[d], 0);
         iv[d] = 1'b0;
      end
      tick();

      // Single word B4, MSB first: 1,0,1,1,0,1,0,0.
      send(0, 8'hB4, 8'b10110100, 1'b0, 20, n);
      chk("t2_accept_wait", n, 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t2_in_ready_bit%0d", i), ir[0], (i == 7) ? 1 : 0);
         chk($sformatf("t2_busy_bit%0d", i), by[0], 1);
         tick();
      end
      chk("t2_after_x_valid", xv[0], 0);
      chk("t2_after_x", xo[0], 0);
      chk("t2_after_busy", by[0], 0);
      tick();

      // Back-to-back B4 then 0F: second accepted on the bit-7 cycle.
      send(0, 8'hB4, 8'b10110100, 1'b0, 20, n);
      send(0, 8'h0F, 8'b00001111, 1'b0, 20, n);
      chk("t3_second_wait", n, 7);
      for (int i = 0; i < 8; i++) tick();
      chk("t3_after_x_valid", xv[0], 0);

      // LSB first: B4 -> 0,0,1,0,1,1,0,1; then B0 -> 0,0,0,0,1,1,0,1 (1101 tail).
      send(1, 8'hB4, 8'b00101101, 1'b0, 20, n);
      send(1, 8'hB0, 8'b00001101, 1'b0, 20, n);
      chk("t4_second_wait", n, 7);
      for (int i = 0; i < 8; i++) tick();
      chk("t4_after_x_valid", xv[1], 0);

      // Mid-word reset at bit_idx 3 of FF, with a handshake offered during rst.
      send(0, 8'hFF, 8'hFF, 1'b0, 20, n);
      for (int i = 0; i < 3; i++) tick();
      chk("t5_bit_idx_before_rst", bi[0], 3);
      rst    = 1'b1;
      iv[0]  = 1'b1;
      din[0] = 8'h3C;
      tick();
      sbq.delete();
      chk("t5_rst_x_valid", xv[0], 0);
      chk("t5_rst_x", xo[0], 0);
      chk("t5_rst_word_done", wd[0], 0);
      chk("t5_rst_in_ready", ir[0], 0);
      chk("t5_rst_busy", by[0], 0);
      rst   = 1'b0;
      iv[0] = 1'b0;
      tick();
      chk("t5_no_accept_in_rst", xv[0], 0);
      send(0, 8'hA5, 8'b10100101, 1'b0, 20, n);
      for (int i = 0; i < 8; i++) tick();
      chk("t5_after_x_valid", xv[0], 0);

      // Gap: three idle cycles between words, then stall with changing data.
      send(0, 8'h3C, 8'b00111100, 1'b0, 20, n);
      for (int i = 0; i < 7; i++) tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t6_gap_x_valid%0d", i), xv[0], 0);
      end
      send(0, 8'h5A, 8'b01011010, 1'b0, 20, n);
      chk("t6_gap_accept_wait", n, 0);
      tick();
      tick();
      chk("t6_stall_start_idx", bi[0], 2);
      send(0, 8'h11, 8'h00, 1'b1, 20, n);
      chk("t6_stall_wait", n, 5);
      for (int i = 0; i < 8; i++) tick();
      chk("t6_after_x_valid", xv[0], 0);

      // WIDTH=1: ready every cycle, word_done == x_valid, idle level 1.
      send(2, 8'h01, 8'h01, 1'b0, 20, n);
      send(2, 8'h00, 8'h00, 1'b0, 20, n);
      chk("w1_wait0", n, 0);
      chk("w1_in_ready_shift", ir[2], 1);
      send(2, 8'h01, 8'h01, 1'b0, 20, n);
      chk("w1_wait1", n, 0);
      send(2, 8'h00, 8'h00, 1'b0, 20, n);
      chk("w1_wait2", n, 0);
      chk("w1_busy", by[2], 1);
      tick();
      chk("w1_after_x_valid", xv[2], 0);
      chk("w1_after_x", xo[2], 1);
      chk("w1_after_busy", by[2], 0);

      for (int i = 0; i < 3; i++) tick();
      chk("scoreboard_empty", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
